uart_rx_work_loader: RTL
========================

Name: uart_rx_work_loader

Overview:
- Packet controller that sequences the byte stream from the 16x-oversampled UART receiver into a fixed-length work payload for the hashing core.
- Hunts for a sync byte, collects PAYLOAD_BYTES data bytes, then checks an 8-bit checksum.
- On a good checksum, publishes the payload on a held output bus with a one-cycle valid strobe. Packets with a bad checksum or an inter-byte timeout are discarded.

Parameters:
- PAYLOAD_BYTES, 44, number of data bytes per packet (32 midstate + 12 data); legal range 1..64.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 4096, maximum clk cycles allowed between consecutive bytes inside a packet; legal range 2..65535.

Ports:
- clk  input  1  system clock (same 16x-baud clock as the UART receiver).
- reset_n  input  1  asynchronous, active-low reset.
- rx_flag  input  1  one-cycle strobe: rx_byte is valid this cycle.
- rx_byte  input  8  received byte.
- work_data  output  PAYLOAD_BYTES*8  last good payload; first received byte occupies the MSB byte.
- work_valid  output  1  one-cycle pulse: work_data was updated this cycle.
- err_checksum  output  1  one-cycle pulse: packet rejected, checksum mismatch.
- err_timeout  output  1  one-cycle pulse: packet abandoned, inter-byte timeout.
- busy  output  1  high while a packet is in progress (any state except IDLE).

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; all outputs, the shift register, the byte counter, the running sum and the timeout counter go to 0.
  - work_data resets to all zeros.
- States:
  - IDLE: on rx_flag with rx_byte==SYNC_BYTE -> PAYLOAD; clear byte count, running sum and timeout counter. Any other byte is ignored and state stays IDLE.
  - PAYLOAD: on rx_flag, shift rx_byte into the LSB byte of the shift register (left shift by 8) and add it to the running sum (mod 256). Increment the byte count. After the byte that makes count==PAYLOAD_BYTES -> CHECKSUM.
  - CHECKSUM: on rx_flag, compute (sum + rx_byte) mod 256.
    - If 0: copy the shift register to work_data and pulse work_valid in the next cycle.
    - Otherwise: pulse err_checksum in the next cycle and leave work_data unchanged.
    - Either way -> IDLE.
- Latency: work_valid / err_checksum assert exactly 1 cycle after the checksum byte's rx_flag cycle. The controller is back in IDLE in that same cycle and can accept a new sync byte immediately.
- Sync byte value inside PAYLOAD or CHECKSUM is ordinary data; no resynchronisation mid-packet.
- Timeout:
  - 16-bit counter, cleared on every rx_flag and in IDLE, incremented each cycle otherwise.
  - If it reaches TIMEOUT_CYCLES-1 in PAYLOAD or CHECKSUM: pulse err_timeout next cycle, -> IDLE, partial data discarded.
  - If rx_flag and the timeout terminal count coincide, rx_flag wins: the byte is accepted and there is no timeout.
- The three pulses are mutually exclusive and never high two cycles in a row from the same packet.
- busy = (state != IDLE), registered with state. It deasserts in the same cycle as the terminal pulse.
- rx_flag held high for several cycles is treated as one byte per high cycle. The upstream receiver guarantees single-cycle strobes, so this is not a concern in the system.
- Reset asserted mid-packet: immediate return to IDLE, no pulses, work_data cleared.
- Checksum byte = two's-complement of the payload byte sum, so that payload sum + checksum == 0 mod 256.

Test Plan:
- Good packet (PAYLOAD_BYTES=4): A5,01,02,03,04,F6 at 160-cycle spacing -> work_data=32'h01020304, work_valid for 1 cycle exactly 1 cycle after the F6 strobe, busy low in that same cycle.
- Bad checksum: A5,01,02,03,04,F7 -> err_checksum pulse; work_data keeps its prior value 32'h01020304; no work_valid.
- Garbage then sync: 00,FF,A5 (in IDLE) with payload 10,20,30,40 and checksum 60 -> leading bytes ignored, work_data=32'h10203040, work_valid.
- Timeout: A5,01,02 then silence, TIMEOUT_CYCLES=300 -> err_timeout exactly 300 cycles after the 02 strobe; busy falls. The next packet A5,AA,BB,CC,DD,F2 is accepted (work_data=32'hAABBCCDD).
- Boundary: a byte strobe on the timeout terminal cycle is accepted with no err_timeout. A5 as payload byte (A5,A5,00,00,00,5B) -> work_data=32'hA5000000, work_valid.
- Reset mid-packet: deassert reset_n after the 2nd payload byte -> outputs 0 asynchronously. After release, a fresh good packet is accepted with no stale bytes.

Source files
------------

// File: rtl/uart_rx_work_loader.sv
// Frames the UART byte stream (sync, payload, 8-bit checksum) into a held work payload.
// Result pulses 1 cycle after the checksum byte; no backpressure, bytes are taken as they arrive.
module uart_rx_work_loader #(
  parameter int          PAYLOAD_BYTES  = 44,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_flag,
  input  logic [7:0]                 rx_byte,
  output logic [PAYLOAD_BYTES*8-1:0] work_data,
  output logic                       work_valid,
  output logic                       err_checksum,
  output logic                       err_timeout,
  output logic                       busy
);

  localparam int W  = PAYLOAD_BYTES * 8;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECKSUM} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    work_data_q, work_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            work_valid_q, work_valid_d;
  logic            err_chk_q, err_chk_d;
  logic            err_tmo_q, err_tmo_d;

  logic [7:0]      final_sum;
  logic            last_byte;
  logic            tmo_hit;
  logic            sync_seen;

  assign final_sum = sum_q + rx_byte;
  assign last_byte = (cnt_q == CW'(PAYLOAD_BYTES - 1));
  assign sync_seen = rx_flag && (rx_byte == SYNC_BYTE);
  // Fires on the cycle the counter would step onto TIMEOUT_CYCLES-1; a byte that same cycle wins.
  assign tmo_hit   = (state_q != ST_IDLE) && !rx_flag && (tmo_q == 16'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sync_seen) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (rx_flag && last_byte) state_d = ST_CHECKSUM;
        else if (tmo_hit)         state_d = ST_IDLE;
      end
      ST_CHECKSUM: begin
        if (rx_flag || tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    work_data_d  = work_data_q;
    work_valid_d = 1'b0;
    err_chk_d    = 1'b0;
    err_tmo_d    = 1'b0;
    tmo_d        = (state_q == ST_IDLE || rx_flag) ? 16'd0 : tmo_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (sync_seen) begin
          cnt_d = '0;
          sum_d = 8'd0;
        end
      end
      ST_PAYLOAD: begin
        if (rx_flag) begin
          shift_d = (shift_q << 8) | W'(rx_byte);
          sum_d   = final_sum;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          err_tmo_d = tmo_hit;
        end
      end
      ST_CHECKSUM: begin
        if (rx_flag) begin
          if (final_sum == 8'd0) begin
            work_data_d  = shift_q;
            work_valid_d = 1'b1;
          end else begin
            err_chk_d = 1'b1;
          end
        end else begin
          err_tmo_d = tmo_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q      <= '0;
      work_data_q  <= '0;
      cnt_q        <= '0;
      sum_q        <= 8'd0;
      tmo_q        <= 16'd0;
      work_valid_q <= 1'b0;
      err_chk_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      work_data_q  <= work_data_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      work_valid_q <= work_valid_d;
      err_chk_q    <= err_chk_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  assign work_data    = work_data_q;
  assign work_valid   = work_valid_q;
  assign err_checksum = err_chk_q;
  assign err_timeout  = err_tmo_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
